// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLLI = 3'b101;
    localparam logic [2:0] ALU_SRLI = 3'b110;
    localparam logic [2:0] ALU_MOV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        STORE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_alu_bit.sv
// Combinational one-bit ALU slice; carry out is only meaningful for ADD/SUB
// and is forced to 0 for every other op so the accumulator carry stays clear.
module serial_alu_bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       res,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        res   = 1'b0;
        cout  = 1'b0;
        b_eff = (op == ALU_SUB) ? ~b : b;
        case (op)
            ALU_ADD, ALU_SUB: begin
                res  = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            ALU_AND:            res = a & b;
            ALU_OR:             res = a | b;
            ALU_XOR:            res = a ^ b;
            ALU_SLLI, ALU_SRLI: res = a;
            ALU_MOV:            res = b;
            default:            res = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_acc.sv
// Bit-serial ALU with accumulator: shifts WIDTH operand bits LSB-first through
// a one-bit ALU, then issues a single parallel write-back strobe.
module serial_alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic             rs1_bit,
    input  logic             rs2_bit,
    output logic             reg_shift_en,
    output logic             reg_store_en,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy,
    output logic             done,
    output logic             carry_flag,
    output logic             zero_flag
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic               carry;
    logic               res;
    logic               cout;
    logic               is_arith;
    logic               last_bit;

    assign is_arith = (op_q == ALU_ADD) || (op_q == ALU_SUB);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    serial_alu_bit u_alu_bit (
        .a    (rs1_bit),
        .b    (rs2_bit),
        .cin  (carry),
        .op   (op_q),
        .res  (res),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Strobes are pure state decodes so the register file sees exactly WIDTH shifts.
    always_comb begin
        state_next   = state;
        reg_shift_en = 1'b0;
        reg_store_en = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                reg_shift_en = 1'b1;
                if (last_bit) state_next = STORE;
            end
            STORE: begin
                reg_store_en = 1'b1;
                done         = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            op_q       <= ALU_ADD;
            carry      <= 1'b0;
            acc_out    <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= alu_op;
                        cnt   <= '0;
                        carry <= (alu_op == ALU_SUB);
                    end
                end
                SHIFT: begin
                    acc_out <= {res, acc_out[WIDTH-1:1]};
                    carry   <= is_arith ? cout : 1'b0;
                    cnt     <= cnt + 1'b1;
                end
                STORE: begin
                    carry_flag <= is_arith & carry;
                    zero_flag  <= (acc_out == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_acc.sv
// Self-checking bench for serial_alu_acc with a behavioural register-file bit feeder.
module tb_serial_alu_acc;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [2:0]       alu_op;
    logic             rs1_bit;
    logic             rs2_bit;
    logic             reg_shift_en;
    logic             reg_store_en;
    logic [WIDTH-1:0] acc_out;
    logic             busy;
    logic             done;
    logic             carry_flag;
    logic             zero_flag;

    logic [7:0] a_reg = 8'h00;
    logic [7:0] b_reg = 8'h00;
    logic [2:0] bit_idx;
    int         shift_cnt = 0;
    int         store_cnt = 0;
    int         errors = 0;
    int         checks = 0;

    serial_alu_acc #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .alu_op       (alu_op),
        .rs1_bit      (rs1_bit),
        .rs2_bit      (rs2_bit),
        .reg_shift_en (reg_shift_en),
        .reg_store_en (reg_store_en),
        .acc_out      (acc_out),
        .busy         (busy),
        .done         (done),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream register file: bit index advances on each shift strobe.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)             bit_idx <= 3'd0;
        else if (reg_shift_en) bit_idx <= bit_idx + 3'd1;
    end

    assign rs1_bit = a_reg[bit_idx];
    assign rs2_bit = b_reg[bit_idx];

    always @(posedge clk) begin
        if (reg_shift_en) shift_cnt++;
        if (reg_store_en) store_cnt++;
    end

    // Reference result {carry, value} straight from the opcode definitions.
    function automatic logic [8:0] refResult(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        case (op)
            ALU_ADD:            s = {1'b0, a} + {1'b0, b};
            ALU_SUB:            s = {1'b0, a} + {1'b0, ~b} + 9'd1;
            ALU_AND:            s = {1'b0, a & b};
            ALU_OR:             s = {1'b0, a | b};
            ALU_XOR:            s = {1'b0, a ^ b};
            ALU_SLLI, ALU_SRLI: s = {1'b0, a};
            default:            s = {1'b0, b};
        endcase
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " shift_en"}, 32'(reg_shift_en), 32'd0);
        checkOutput({tag, " store_en"}, 32'(reg_store_en), 32'd0);
        checkOutput({tag, " acc_out"},  32'(acc_out),      32'd0);
        checkOutput({tag, " busy"},     32'(busy),         32'd0);
        checkOutput({tag, " done"},     32'(done),         32'd0);
        checkOutput({tag, " carry"},    32'(carry_flag),   32'd0);
        checkOutput({tag, " zero"},     32'(zero_flag),    32'd0);
    endtask

    // Runs one operation from a negedge; disturb pulses start and flips alu_op mid-flight.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input bit disturb, input string tag);
        logic [8:0] exp;
        int         lat;
        exp       = refResult(op, a, b);
        a_reg     = a;
        b_reg     = b;
        alu_op    = op;
        start     = 1'b1;
        shift_cnt = 0;
        store_cnt = 0;
        lat       = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = disturb && (k == 3 || k == 8 || k == 9);
            if (disturb && k >= 2) alu_op = ~op;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, 32'(lat), 32'(WIDTH + 1));
        checkOutput({tag, " busy@store"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, " acc_out"}, 32'(acc_out), 32'(exp[7:0]));
        checkOutput({tag, " carry"}, 32'(carry_flag), 32'(exp[8]));
        checkOutput({tag, " zero"}, 32'(zero_flag), 32'(exp[7:0] == 8'h00));
        checkOutput({tag, " done width"}, 32'(done), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
        checkOutput({tag, " shifts"}, 32'(shift_cnt), 32'(WIDTH));
        checkOutput({tag, " stores"}, 32'(store_cnt), 32'd1);
        alu_op = op;
    endtask

    initial begin
        int          done_times[$];
        int          double_done;
        logic        prev_done;
        logic [2:0]  rop;
        logic [7:0]  ra, rb;

        rstn   = 1'b0;
        start  = 1'b0;
        alu_op = ALU_ADD;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rstn = 1'b1;
        @(negedge clk);

        applyStimulus(ALU_ADD, 8'h05, 8'h03, 1'b0, "add 05+03");
        applyStimulus(ALU_SUB, 8'h03, 8'h05, 1'b0, "sub 03-05");
        applyStimulus(ALU_SUB, 8'h05, 8'h05, 1'b0, "sub 05-05");
        applyStimulus(ALU_ADD, 8'hFF, 8'h01, 1'b0, "add ff+01");
        applyStimulus(ALU_XOR, 8'hA5, 8'hFF, 1'b0, "xor a5^ff");
        applyStimulus(ALU_SUB, 8'h3C, 8'h11, 1'b1, "sub disturbed");

        // Reset during the fourth shift cycle must abort without a store.
        a_reg     = 8'h77;
        b_reg     = 8'h11;
        alu_op    = ALU_ADD;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        repeat (3) @(negedge clk);
        store_cnt = 0;
        rstn      = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (12) @(negedge clk);
        checkOutput("midreset stores", 32'(store_cnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        applyStimulus(ALU_OR, 8'h50, 8'h0A, 1'b0, "after reset");

        // Start held high: one accept per WIDTH+2 cycles, single-cycle done pulses.
        a_reg       = 8'h21;
        b_reg       = 8'h12;
        alu_op      = ALU_ADD;
        start       = 1'b1;
        prev_done   = 1'b0;
        double_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) done_times.push_back(k);
            if (done && prev_done) double_done++;
            prev_done = done;
        end
        start = 1'b0;
        checkOutput("b2b done count", 32'(done_times.size()), 32'd4);
        checkOutput("b2b pulse width", 32'(double_done), 32'd0);
        for (int i = 1; i < done_times.size(); i++)
            checkOutput("b2b interval", 32'(done_times[i] - done_times[i-1]), 32'(WIDTH + 2));
        repeat (12) @(negedge clk);
        checkOutput("b2b acc_out", 32'(acc_out), 32'h33);
        checkOutput("b2b idle", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            applyStimulus(rop, ra, rb, i[0], $sformatf("rand%0d op%0d", i, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
